alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 152 +++++++++++++++
 tb/tb_alu_seq.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Small sequencer that owns an 8 x 16-bit register file and drives an
// external combinational ALU. One command is accepted at a time; ALU commands
// take one EXEC cycle, while LOADI, READ and reserved ops go straight to DONE.
//
// Ports
//   clk                     system clock, rising edge
//   reset                   asynchronous, active-low
//   cmd_valid / cmd_ready   command handshake (ready only in IDLE)
//   cmd_op                  000 ADD, 001 SUB, 010 AND, 011 OR,
//                           100 LOADI, 101 READ, 11x reserved
//   cmd_rd/cmd_rs/cmd_rt    destination / source A / source B index
//   cmd_imm                 LOADI immediate
//   alu_op/alu_a/alu_b      registered operands to the external ALU
//   alu_o/alu_cout          ALU result and carry-out (sub: 1 = no borrow)
//   done                    one-cycle completion pulse
//   res_data                result of the last completed command
//   flag_c/flag_z           carry / zero flags of the last ALU command
// ---------------------------------------------------------------------------
module alu_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [2:0]  cmd_rd,
    input  logic [2:0]  cmd_rs,
    input  logic [2:0]  cmd_rt,
    input  logic [15:0] cmd_imm,
    output logic [1:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_o,
    input  logic        alu_cout,
    output logic        done,
    output logic [15:0] res_data,
    output logic        flag_c,
    output logic        flag_z
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q,    state_d;
    logic [15:0] rf_q [8];
    logic [15:0] rf_d [8];
    logic [15:0] res_data_q, res_data_d;
    logic [1:0]  alu_op_q,   alu_op_d;
    logic [15:0] alu_a_q,    alu_a_d;
    logic [15:0] alu_b_q,    alu_b_d;
    logic        flag_c_q,   flag_c_d;
    logic        flag_z_q,   flag_z_d;
    logic [2:0]  rd_q,       rd_d;

    // Next-state logic. Operands are captured into alu_a/alu_b at accept,
    // so a destination that aliases a source still sees the pre-write value.
    // The destination index is latched as well because cmd_* is only
    // meaningful on the accept edge.
    always_comb begin
        state_d    = state_q;
        rf_d       = rf_q;
        res_data_d = res_data_q;
        alu_op_d   = alu_op_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        flag_c_d   = flag_c_q;
        flag_z_d   = flag_z_q;
        rd_d       = rd_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            alu_op_d = cmd_op[1:0];
                            alu_a_d  = rf_q[cmd_rs];
                            alu_b_d  = rf_q[cmd_rt];
                            rd_d     = cmd_rd;
                            state_d  = EXEC;
                        end
                        3'b100: begin
                            rf_d[cmd_rd] = cmd_imm;
                            res_data_d   = cmd_imm;
                            state_d      = DONE;
                        end
                        3'b101: begin
                            res_data_d = rf_q[cmd_rs];
                            state_d    = DONE;
                        end
                        default: begin
                            res_data_d = 16'h0000;
                            state_d    = DONE;
                        end
                    endcase
                end
            end
            EXEC: begin
                rf_d[rd_q] = alu_o;
                res_data_d = alu_o;
                flag_c_d   = alu_cout;
                flag_z_d   = (alu_o == 16'h0000);
                state_d    = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. Reset wipes everything, which also aborts any
    // command in flight before it can write back or pulse done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= 16'h0000;
            end
            res_data_q <= 16'h0000;
            alu_op_q   <= 2'b00;
            alu_a_q    <= 16'h0000;
            alu_b_q    <= 16'h0000;
            flag_c_q   <= 1'b0;
            flag_z_q   <= 1'b0;
            rd_q       <= 3'd0;
        end else begin
            state_q    <= state_d;
            rf_q       <= rf_d;
            res_data_q <= res_data_d;
            alu_op_q   <= alu_op_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            flag_c_q   <= flag_c_d;
            flag_z_q   <= flag_z_d;
            rd_q       <= rd_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign done      = (state_q == DONE);
    assign res_data  = res_data_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign flag_c    = flag_c_q;
    assign flag_z    = flag_z_q;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Directed self-checking bench for alu_seq. A behavioural ALU model drives
// alu_o/alu_cout from the DUT's registered operands. Each task covers one
// scenario and compares observed outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_rs;
    logic [2:0]  cmd_rt;
    logic [15:0] cmd_imm;
    logic [1:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_o;
    logic        alu_cout;
    logic        done;
    logic [15:0] res_data;
    logic        flag_c;
    logic        flag_z;

    int n_cmp;
    int n_fail;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_LOADI = 3'b100;
    localparam logic [2:0] OP_READ  = 3'b101;
    localparam logic [2:0] OP_RSV   = 3'b110;

    alu_seq dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rs    (cmd_rs),
        .cmd_rt    (cmd_rt),
        .cmd_imm   (cmd_imm),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_o     (alu_o),
        .alu_cout  (alu_cout),
        .done      (done),
        .res_data  (res_data),
        .flag_c    (flag_c),
        .flag_z    (flag_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: 17-bit result so bit 16 is the carry; subtraction is
    // a + ~b + 1, giving carry 1 when there is no borrow.
    logic [16:0] alu_full;
    always_comb begin
        alu_full = 17'd0;
        case (alu_op)
            2'b00: alu_full = {1'b0, alu_a} + {1'b0, alu_b};
            2'b01: alu_full = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
            2'b10: alu_full = {1'b0, alu_a & alu_b};
            default: alu_full = {1'b0, alu_a | alu_b};
        endcase
    end
    assign alu_o    = alu_full[15:0];
    assign alu_cout = alu_full[16];

    // Issue one command from IDLE and return at the negedge where done is
    // seen. lat counts cycles from the accept edge (1 = cycle after it);
    // -1 means done never appeared. The ALU outputs seen in the first cycle
    // after accept (EXEC for ALU ops) are returned too.
    task automatic do_cmd(input logic [2:0] op, input logic [2:0] rd,
                          input logic [2:0] rs, input logic [2:0] rt,
                          input logic [15:0] imm, output int lat,
                          output logic [1:0] ex_op, output logic [15:0] ex_a,
                          output logic [15:0] ex_b);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!cmd_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs    = rs;
        cmd_rt    = rt;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat   = -1;
        ex_op = 2'b00;
        ex_a  = 16'h0000;
        ex_b  = 16'h0000;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                ex_op = alu_op;
                ex_a  = alu_a;
                ex_b  = alu_b;
            end
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    // Async reset with no clock edge, then every register reads back zero.
    task automatic test_reset();
        int lat;
        logic [1:0] eo;
        logic [15:0] ea, eb;
        do_cmd(OP_LOADI, 3'd0, 3'd0, 3'd0, 16'hFFFF, lat, eo, ea, eb);
        do_cmd(OP_SUB, 3'd1, 3'd0, 3'd2, 16'h0000, lat, eo, ea, eb);
        n_cmp++;
        if (res_data !== 16'hFFFF || flag_c !== 1'b1 || alu_op !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_sub: res=%h c=%b op=%b expected res=ffff c=1 op=01",
                     res_data, flag_c, alu_op);
        end
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({res_data, alu_op, alu_a, alu_b, flag_c, flag_z, done, cmd_ready} !==
            {16'h0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL async_reset: res=%h op=%b a=%h b=%h c=%b z=%b done=%b rdy=%b expected all 0, rdy=1",
                     res_data, alu_op, alu_a, alu_b, flag_c, flag_z, done, cmd_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int r = 0; r < 8; r++) begin
            do_cmd(OP_READ, 3'd0, 3'(r), 3'd0, 16'h0000, lat, eo, ea, eb);
            n_cmp++;
            if (res_data !== 16'h0000 || lat !== 1) begin
                n_fail++;
                $display("[TB] FAIL reset_read_r%0d: res=%h lat=%0d expected res=0000 lat=1",
                         r, res_data, lat);
            end
        end
    endtask

    // LOADI completes one cycle after accept; ADD two, with operands on the
    // ALU bus during EXEC.
    task automatic test_add();
        int lat;
        logic [1:0] eo;
        logic [15:0] ea, eb;
        do_cmd(OP_LOADI, 3'd1, 3'd0, 3'd0, 16'h0005, lat, eo, ea, eb);
        n_cmp++;
        if (res_data !== 16'h0005 || lat !== 1) begin
            n_fail++;
            $display("[TB] FAIL loadi_r1: res=%h lat=%0d expected res=0005 lat=1", res_data, lat);
        end
        do_cmd(OP_LOADI, 3'd2, 3'd0, 3'd0, 16'h0003, lat, eo, ea, eb);
        do_cmd(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0000, lat, eo, ea, eb);
        n_cmp++;
        if (eo !== 2'b00 || ea !== 16'h0005 || eb !== 16'h0003) begin
            n_fail++;
            $display("[TB] FAIL add_exec_bus: op=%b a=%h b=%h expected op=00 a=0005 b=0003", eo, ea, eb);
        end
        n_cmp++;
        if (res_data !== 16'h0008 || flag_c !== 1'b0 || flag_z !== 1'b0 || lat !== 2) begin
            n_fail++;
            $display("[TB] FAIL add_result: res=%h c=%b z=%b lat=%0d expected res=0008 c=0 z=0 lat=2",
                     res_data, flag_c, flag_z, lat);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL add_done_width: done=%b rdy=%b expected done=0 rdy=1", done, cmd_ready);
        end
    endtask

    // Borrow, exact zero, and 16-bit wrap-around.
    task automatic test_sub_wrap();
        int lat;
        logic [1:0] eo;
        logic [15:0] ea, eb;
        do_cmd(OP_SUB, 3'd4, 3'd2, 3'd1, 16'h0000, lat, eo, ea, eb);
        n_cmp++;
        if (res_data !== 16'hFFFE || flag_c !== 1'b0 || flag_z !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL sub_borrow: res=%h c=%b z=%b expected res=fffe c=0 z=0", res_data, flag_c, flag_z);
        end
        do_cmd(OP_SUB, 3'd5, 3'd1, 3'd1, 16'h0000, lat, eo, ea, eb);
        n_cmp++;
        if (res_data !== 16'h0000 || flag_c !== 1'b1 || flag_z !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL sub_zero: res=%h c=%b z=%b expected res=0000 c=1 z=1", res_data, flag_c, flag_z);
        end
        do_cmd(OP_LOADI, 3'd6, 3'd0, 3'd0, 16'hFFFF, lat, eo, ea, eb);
        do_cmd(OP_LOADI, 3'd7, 3'd0, 3'd0, 16'h0001, lat, eo, ea, eb);
        do_cmd(OP_ADD, 3'd0, 3'd6, 3'd7, 16'h0000, lat, eo, ea, eb);
        n_cmp++;
        if (res_data !== 16'h0000 || flag_c !== 1'b1 || flag_z !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL add_wrap: res=%h c=%b z=%b expected res=0000 c=1 z=1", res_data, flag_c, flag_z);
        end
    endtask

    // Logic ops, aliasing destination, READ/reserved leave flags and ALU bus.
    task automatic test_logic_read();
        int lat;
        logic [1:0] eo;
        logic [15:0] ea, eb;
        do_cmd(OP_LOADI, 3'd6, 3'd0, 3'd0, 16'hF0F0, lat, eo, ea, eb);
        do_cmd(OP_LOADI, 3'd7, 3'd0, 3'd0, 16'h0FF0, lat, eo, ea, eb);
        do_cmd(OP_AND, 3'd0, 3'd6, 3'd7, 16'h0000, lat, eo, ea, eb);
        n_cmp++;
        if (res_data !== 16'h00F0 || eo !== 2'b10 || flag_z !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL and_op: res=%h op=%b z=%b expected res=00f0 op=10 z=0", res_data, eo, flag_z);
        end
        do_cmd(OP_OR, 3'd0, 3'd6, 3'd7, 16'h0000, lat, eo, ea, eb);
        n_cmp++;
        if (res_data !== 16'hFFF0 || eo !== 2'b11) begin
            n_fail++;
            $display("[TB] FAIL or_op: res=%h op=%b expected res=fff0 op=11", res_data, eo);
        end
        do_cmd(OP_ADD, 3'd1, 3'd1, 3'd1, 16'h0000, lat, eo, ea, eb);
        n_cmp++;
        if (res_data !== 16'h000A || ea !== 16'h0005 || eb !== 16'h0005) begin
            n_fail++;
            $display("[TB] FAIL add_alias: res=%h a=%h b=%h expected res=000a a=0005 b=0005", res_data, ea, eb);
        end
        do_cmd(OP_SUB, 3'd5, 3'd1, 3'd1, 16'h0000, lat, eo, ea, eb);
        do_cmd(OP_READ, 3'd0, 3'd1, 3'd0, 16'h0000, lat, eo, ea, eb);
        n_cmp++;
        if (res_data !== 16'h000A || flag_c !== 1'b1 || flag_z !== 1'b1 || lat !== 1) begin
            n_fail++;
            $display("[TB] FAIL read_r1: res=%h c=%b z=%b lat=%0d expected res=000a c=1 z=1 lat=1",
                     res_data, flag_c, flag_z, lat);
        end
        n_cmp++;
        if (alu_op !== 2'b01 || alu_a !== 16'h000A || alu_b !== 16'h000A) begin
            n_fail++;
            $display("[TB] FAIL alu_bus_hold: op=%b a=%h b=%h expected op=01 a=000a b=000a", alu_op, alu_a, alu_b);
        end
        do_cmd(OP_RSV, 3'd1, 3'd1, 3'd1, 16'h1234, lat, eo, ea, eb);
        n_cmp++;
        if (res_data !== 16'h0000 || flag_c !== 1'b1 || flag_z !== 1'b1 || lat !== 1) begin
            n_fail++;
            $display("[TB] FAIL reserved_op: res=%h c=%b z=%b lat=%0d expected res=0000 c=1 z=1 lat=1",
                     res_data, flag_c, flag_z, lat);
        end
        do_cmd(OP_READ, 3'd0, 3'd1, 3'd0, 16'h0000, lat, eo, ea, eb);
        n_cmp++;
        if (res_data !== 16'h000A) begin
            n_fail++;
            $display("[TB] FAIL reserved_nowrite: res=%h expected 000a", res_data);
        end
    endtask

    // cmd_valid held for 10 edges with ADD r3=r1+r1: accepts land on edges
    // 0,3,6,9 only, so ready/done follow a period-3 pattern and 4 dones occur.
    task automatic test_back_to_back();
        int n_done;
        @(negedge clk);
        cmd_op    = OP_ADD;
        cmd_rd    = 3'd3;
        cmd_rs    = 3'd1;
        cmd_rt    = 3'd1;
        cmd_imm   = 16'h0000;
        cmd_valid = 1'b1;
        n_done    = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            if (done) n_done++;
            n_cmp++;
            if (cmd_ready !== (i % 3 == 0) || done !== (i % 3 == 2)) begin
                n_fail++;
                $display("[TB] FAIL b2b_cycle%0d: rdy=%b done=%b expected rdy=%b done=%b",
                         i, cmd_ready, done, (i % 3 == 0), (i % 3 == 2));
            end
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        n_cmp++;
        if (n_done !== 4 || res_data !== 16'h0014) begin
            n_fail++;
            $display("[TB] FAIL b2b_done_count: dones=%0d res=%h expected dones=4 res=0014", n_done, res_data);
        end
    endtask

    // Reset during EXEC aborts the ADD: no done pulse, r3 stays cleared.
    task automatic test_reset_abort();
        int lat;
        int n_done;
        logic [1:0] eo;
        logic [15:0] ea, eb;
        do_cmd(OP_LOADI, 3'd1, 3'd0, 3'd0, 16'h0007, lat, eo, ea, eb);
        do_cmd(OP_LOADI, 3'd2, 3'd0, 3'd0, 16'h0009, lat, eo, ea, eb);
        @(negedge clk);
        cmd_op    = OP_ADD;
        cmd_rd    = 3'd3;
        cmd_rs    = 3'd1;
        cmd_rt    = 3'd2;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n_done = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        if (done) n_done++;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        n_cmp++;
        if (n_done !== 0) begin
            n_fail++;
            $display("[TB] FAIL abort_no_done: dones=%0d expected 0", n_done);
        end
        do_cmd(OP_READ, 3'd0, 3'd3, 3'd0, 16'h0000, lat, eo, ea, eb);
        n_cmp++;
        if (res_data !== 16'h0000 || lat !== 1) begin
            n_fail++;
            $display("[TB] FAIL abort_r3: res=%h lat=%0d expected res=0000 lat=1", res_data, lat);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_rd    = 3'd0;
        cmd_rs    = 3'd0;
        cmd_rt    = 3'd0;
        cmd_imm   = 16'h0000;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        test_reset();
        test_add();
        test_sub_wrap();
        test_logic_read();
        test_back_to_back();
        test_reset_abort();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
